mismatch_scanner: RTL
=====================

// Module: mismatch_scanner
// PURPOSE
//  Sequential companion to the N-bit equality comparator: accepts an operand pair,
//  forms the XOR difference vector and, on mismatch, streams the index of every
//  differing bit (LSB first) over a valid/ready handshake. Sits behind the compare
//  stage in the datapath for diagnostics/fault localisation; reports equality too.
// PARAMETERS
//  N   32  operand width (N >= 2)
//  IW  5   index width, = clog2(N); caller keeps consistent with N
// PORTS
//  clk        in   1     single clock, all logic on posedge
//  rst_n      in   1     synchronous, active-low reset
//  in_valid   in   1     operand pair a/b valid
//  in_ready   out  1     scanner idle, can accept operands
//  a          in   N     operand A
//  b          in   N     operand B
//  idx_valid  out  1     idx holds a mismatching bit position
//  idx_ready  in   1     consumer takes idx
//  idx        out  IW    position of current lowest remaining mismatching bit
//  idx_last   out  1     idx is the final mismatch of this pair
//  done       out  1     one-cycle pulse: pair fully processed
//  equal      out  1     result of last pair: 1 = a==b
//  mm_count   out  IW+1  popcount(a^b) of last pair (only with MISMATCH_COUNT_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, diff=0, idx_valid=0, idx=0,
//    idx_last=0, done=0, equal=0, mm_count=0. in_ready=0 while rst_n=0.
//  - States: IDLE, SCAN, DONE. Registers: diff[N-1:0], equal, mm_count.
//  - IDLE: in_ready=1. Accept on in_valid&in_ready at edge k: diff<=a^b.
//    diff==0 -> equal<=1, go DONE; else equal<=0, go SCAN. in_valid ignored
//    in any other state (no accept, no buffering).
//  - SCAN: idx_valid=1; idx=lowest set bit of diff; idx_last=(diff has exactly
//    one bit set). First idx_valid in cycle k+1. On idx_valid&idx_ready: clear
//    that bit of diff; if idx_last go DONE else stay SCAN (next idx next cycle,
//    so back-to-back transfers at 1 index/cycle with idx_ready held high).
//  - idx_valid&!idx_ready: idx, idx_last, diff held stable; no timeout.
//  - DONE: done=1 for exactly one cycle, idx_valid=0, then IDLE. Equal pair:
//    done at cycle k+1; K mismatches, idx_ready always 1: done at cycle k+1+K.
//  - equal / mm_count hold from cycle k+1 until the next accepted pair.
//  - Bit N-1 mismatch: idx=N-1, no wrap; all-bits mismatch: N transfers.
//  - rst_n low mid-SCAN/DONE: pair aborted, no further idx, no done pulse.
//  - All outputs registered or decoded only from state/diff; no a/b->out comb path.
// CONFIGURATION
//  MISMATCH_COUNT_EN defined: mm_count port present; at accept mm_count<=
//    popcount(a^b) (0..N), visible from cycle k+1.
//  Not defined: mm_count port and popcount logic absent; all else identical.
// TESTING
//  1 a=b=32'hDEADBEEF -> no idx_valid; done at k+1; equal=1; mm_count=0.
//  2 a=32'h0, b=32'h8000_0011, idx_ready=1 -> idx 0,4,31 on consecutive
//    cycles, idx_last only with 31; done next cycle; equal=0; mm_count=3.
//  3 a=0,b=32'h6, idx_ready low 5 cycles -> idx=1 held stable, then 1,2; done once.
//  4 a=0,b=32'hFFFF_FFFF -> 32 indices 0..31 in order, idx_last at 31; mm_count=32.
//  5 rst_n low for 1 cycle after 2nd idx of test 4 -> idx_valid=0, no done,
//    in_ready=1 after release; new pair a=b accepted and done with equal=1.
//  6 in_valid held high during SCAN with new a/b -> ignored; accepted only after
//    DONE->IDLE, one extra cycle later.

Source files
------------

// File: rtl/mismatch_scanner.sv
// Streams the bit index of every mismatch between two operands, LSB first, over valid/ready.
// Optional feature macro MISMATCH_COUNT_EN adds the mm_count port (popcount of a^b).
module mismatch_scanner #(
    parameter int N  = 32,
    parameter int IW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic          idx_valid,
    input  logic          idx_ready,
    output logic [IW-1:0] idx,
    output logic          idx_last,
    output logic          done,
    output logic          equal
`ifdef MISMATCH_COUNT_EN
    ,
    output logic [IW:0]   mm_count
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t        state, state_nxt;
    logic [N-1:0]  diff, diff_nxt;
    logic          equal_nxt;
    logic [IW-1:0] lo_idx;
    logic          one_hot;
    logic          accept;

    // Lowest set bit wins: scan high to low so the last hit overrides.
    always_comb begin
        lo_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (diff[i]) lo_idx = IW'(i);
    end

    assign one_hot   = (diff != '0) && ((diff & (diff - ONE)) == '0);
    assign in_ready  = rst_n && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign idx_valid = (state == SCAN);
    assign idx       = lo_idx;
    assign idx_last  = (state == SCAN) && one_hot;
    assign done      = (state == DONE);

    always_comb begin
        state_nxt = state;
        diff_nxt  = diff;
        equal_nxt = equal;
        case (state)
            IDLE: begin
                if (accept) begin
                    diff_nxt = a ^ b;
                    if ((a ^ b) == '0) begin
                        equal_nxt = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        equal_nxt = 1'b0;
                        state_nxt = SCAN;
                    end
                end
            end
            SCAN: begin
                if (idx_ready) begin
                    // Clearing the lowest set bit exposes the next index.
                    diff_nxt = diff & (diff - ONE);
                    if (one_hot) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef MISMATCH_COUNT_EN
    function automatic logic [IW:0] popcnt(input logic [N-1:0] v);
        logic [IW:0] c;
        c = '0;
        for (int i = 0; i < N; i++)
            c = c + {{IW{1'b0}}, v[i]};
        return c;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            diff  <= '0;
            equal <= 1'b0;
`ifdef MISMATCH_COUNT_EN
            mm_count <= '0;
`endif
        end else begin
            state <= state_nxt;
            diff  <= diff_nxt;
            equal <= equal_nxt;
`ifdef MISMATCH_COUNT_EN
            if (accept) mm_count <= popcnt(a ^ b);
`endif
        end
    end

endmodule
